// File: rtl/beat_seq_pkg.sv
// Shared state encoding and defaults for the beat sequencer.
// Optional ping-pong loop mode is enabled in beat_sequencer with BEAT_SEQ_PINGPONG_EN.
package beat_seq_pkg;

    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_LOOP  = 2'd2
    } state_t;

    localparam int DEFAULT_NOTE_BEATS = 4;

endpackage

// File: rtl/loop_window_calc.sv
// Combinational loop-window calculator: turns the current beat, direction and
// note count into a note-aligned [loop_start, loop_end] window clipped to the song.
module loop_window_calc
    import beat_seq_pkg::*;
#(
    parameter int IBEAT_W    = 12,
    parameter int LEN        = 4095,
    parameter int NOTE_BEATS = DEFAULT_NOTE_BEATS,
    parameter int LOOP_W     = 3
) (
    input  logic [IBEAT_W-1:0] ibeat,
    input  logic               reverse,
    input  logic [LOOP_W-1:0]  loop_notes,
    output logic [IBEAT_W-1:0] loop_start,
    output logic [IBEAT_W-1:0] loop_end
);

    localparam int NB_W = $clog2(NOTE_BEATS);
    localparam int SW   = LOOP_W + NB_W;
    localparam int AW   = ((SW > IBEAT_W) ? SW : IBEAT_W) + 1;
    localparam logic [AW-1:0] LAST      = AW'(LEN - 1);
    localparam logic [AW-1:0] NOTE_MASK = AW'(NOTE_BEATS - 1);

    logic [AW-1:0] span;
    logic [AW-1:0] beat;
    logic [AW-1:0] end_raw;
    logic [AW-1:0] start_v;
    logic [AW-1:0] end_v;

    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        span    = (loop_notes == '0) ? AW'(NOTE_BEATS) : (AW'(loop_notes) << NB_W);
        beat    = AW'(ibeat);
        end_raw = '0;
        start_v = '0;
        end_v   = '0;
        if (reverse) begin
            start_v = beat & ~NOTE_MASK;
            end_raw = start_v + span - AW'(1);
            end_v   = (end_raw > LAST) ? LAST : end_raw;
        end else begin
            end_raw = beat | NOTE_MASK;
            end_v   = (end_raw > LAST) ? LAST : end_raw;
            start_v = ((end_v + AW'(1)) >= span) ? (end_v + AW'(1) - span) : '0;
        end
        loop_start = IBEAT_W'(start_v);
        loop_end   = IBEAT_W'(end_v);
    end

endmodule

// File: rtl/beat_sequencer.sv
// Beat-index sequencer: play/pause, reverse, note-aligned loop window, seek and wrap strobe,
// stepping only on beat_tick. Define BEAT_SEQ_PINGPONG_EN for ping-pong looping.
module beat_sequencer
    import beat_seq_pkg::*;
#(
    parameter int IBEAT_W    = 12,
    parameter int LEN        = 4095,
    parameter int NOTE_BEATS = DEFAULT_NOTE_BEATS,
    parameter int LOOP_W     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               beat_tick,
    input  logic               play,
    input  logic               reverse,
    input  logic               loop_en,
    input  logic [LOOP_W-1:0]  loop_notes,
    input  logic               seek_valid,
    input  logic [IBEAT_W-1:0] seek_ibeat,
    output logic [IBEAT_W-1:0] ibeat,
    output logic [1:0]         state,
    output logic               looping,
    output logic               wrap
);

    localparam int W1 = IBEAT_W + 1;
    localparam logic [W1-1:0] LAST = W1'(LEN - 1);

    state_t             state_q, state_d;
    logic [IBEAT_W-1:0] ibeat_q, ibeat_d;
    logic               wrap_q, wrap_d;
    logic [IBEAT_W-1:0] lstart_q, lend_q;
    logic [IBEAT_W-1:0] cap_start, cap_end;
    logic               win_valid_q, win_valid_d;
    logic               loop_en_q;
    logic               loop_rise;
    logic               capture;
    logic               eff_rev;

    logic [W1-1:0] cur, far, lin_nxt, loop_nxt, seek_clip;
    logic          lin_wrap, loop_wrap;

`ifdef BEAT_SEQ_PINGPONG_EN
    logic dir_q, dir_d;
    logic flip;
    assign eff_rev = reverse ^ dir_q;
`else
    assign eff_rev = reverse;
`endif

    assign loop_rise = loop_en & ~loop_en_q;

    loop_window_calc #(
        .IBEAT_W    (IBEAT_W),
        .LEN        (LEN),
        .NOTE_BEATS (NOTE_BEATS),
        .LOOP_W     (LOOP_W)
    ) u_window (
        .ibeat      (ibeat_q),
        .reverse    (reverse),
        .loop_notes (loop_notes),
        .loop_start (cap_start),
        .loop_end   (cap_end)
    );

    // Candidate next beat for a linear step and for a step inside the loop window.
    always_comb begin
        cur       = {1'b0, ibeat_q};
        far       = eff_rev ? {1'b0, lstart_q} : {1'b0, lend_q};
        lin_nxt   = cur;
        lin_wrap  = 1'b0;
        seek_clip = ({1'b0, seek_ibeat} > LAST) ? LAST : {1'b0, seek_ibeat};
        if (eff_rev) begin
            if (cur == '0) begin
                lin_nxt  = LAST;
                lin_wrap = 1'b1;
            end else begin
                lin_nxt = cur - W1'(1);
            end
        end else begin
            if (cur == LAST) begin
                lin_nxt  = '0;
                lin_wrap = 1'b1;
            end else begin
                lin_nxt = cur + W1'(1);
            end
        end
        loop_nxt  = lin_nxt;
        loop_wrap = lin_wrap;
`ifdef BEAT_SEQ_PINGPONG_EN
        flip = 1'b0;
        if (cur == far) begin
            loop_nxt  = eff_rev ? (cur + W1'(1)) : (cur - W1'(1));
            loop_wrap = 1'b1;
            flip      = 1'b1;
        end else if (lin_nxt == far) begin
            loop_wrap = 1'b1;
            flip      = 1'b1;
        end
`else
        if (cur == far) begin
            loop_nxt  = eff_rev ? {1'b0, lend_q} : {1'b0, lstart_q};
            loop_wrap = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        ibeat_d     = ibeat_q;
        wrap_d      = 1'b0;
        capture     = 1'b0;
        win_valid_d = win_valid_q & loop_en;
`ifdef BEAT_SEQ_PINGPONG_EN
        dir_d       = dir_q;
`endif
        if (seek_valid) begin
            ibeat_d     = IBEAT_W'(seek_clip);
            state_d     = play ? ST_PLAY : ST_PAUSE;
            win_valid_d = 1'b0;
        end else if (!play) begin
            state_d = ST_PAUSE;
        end else begin
            case (state_q)
                ST_PAUSE: state_d = (loop_en && win_valid_q) ? ST_LOOP : ST_PLAY;
                ST_PLAY: begin
                    if (loop_rise) begin
                        capture     = 1'b1;
                        win_valid_d = 1'b1;
                        state_d     = ST_LOOP;
                    end else if (beat_tick) begin
                        ibeat_d = IBEAT_W'(lin_nxt);
                        wrap_d  = lin_wrap;
                    end
                end
                ST_LOOP: begin
                    if (!loop_en) begin
                        state_d = ST_PLAY;
                        if (beat_tick) begin
                            ibeat_d = IBEAT_W'(lin_nxt);
                            wrap_d  = lin_wrap;
                        end
                    end else if (beat_tick) begin
                        ibeat_d = IBEAT_W'(loop_nxt);
                        wrap_d  = loop_wrap;
`ifdef BEAT_SEQ_PINGPONG_EN
                        if (flip) dir_d = ~dir_q;
`endif
                    end
                end
                default: state_d = ST_PAUSE;
            endcase
        end
`ifdef BEAT_SEQ_PINGPONG_EN
        if (state_d != ST_LOOP) dir_d = 1'b0;
`endif
    end

    // NOTE: reset is sampled on the clock edge, and all state updates use non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_PAUSE;
            ibeat_q     <= '0;
            wrap_q      <= 1'b0;
            lstart_q    <= '0;
            lend_q      <= '0;
            win_valid_q <= 1'b0;
            loop_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ibeat_q     <= ibeat_d;
            wrap_q      <= wrap_d;
            win_valid_q <= win_valid_d;
            loop_en_q   <= loop_en;
            if (capture) begin
                lstart_q <= cap_start;
                lend_q   <= cap_end;
            end
        end
    end

`ifdef BEAT_SEQ_PINGPONG_EN
    always_ff @(posedge clk) begin
        if (!rst) dir_q <= 1'b0;
        else      dir_q <= dir_d;
    end
`endif

    assign ibeat   = ibeat_q;
    assign state   = state_q;
    assign looping = (state_q == ST_LOOP);
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed, table-driven bench for beat_sequencer with LEN=64 and hand-computed expectations.
module tb_beat_sequencer;

    localparam int IBEAT_W = 8;
    localparam int LEN     = 64;
    localparam int LOOP_W  = 3;
    localparam int PA = 0, PL = 1, LP = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               beat_tick;
    logic               play;
    logic               reverse;
    logic               loop_en;
    logic [LOOP_W-1:0]  loop_notes;
    logic               seek_valid;
    logic [IBEAT_W-1:0] seek_ibeat;
    logic [IBEAT_W-1:0] ibeat;
    logic [1:0]         state;
    logic               looping;
    logic               wrap;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit sv; int sk; bit pl; bit rv; bit le; int ln; bit tk;
        int e_ibeat; int e_state; bit e_wrap;
    } vec_t;

    vec_t vq[$];

    beat_sequencer #(
        .IBEAT_W    (IBEAT_W),
        .LEN        (LEN),
        .NOTE_BEATS (4),
        .LOOP_W     (LOOP_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .beat_tick  (beat_tick),
        .play       (play),
        .reverse    (reverse),
        .loop_en    (loop_en),
        .loop_notes (loop_notes),
        .seek_valid (seek_valid),
        .seek_ibeat (seek_ibeat),
        .ibeat      (ibeat),
        .state      (state),
        .looping    (looping),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input bit sv, input int sk, input bit pl, input bit rv, input bit le,
                       input int ln, input bit tk, input int eb, input int es, input bit ew);
        vec_t v;
        v = '{sv, sk, pl, rv, le, ln, tk, eb, es, ew};
        vq.push_back(v);
    endtask

    task automatic check_outputs(input string tag, input int eb, input int es, input bit ew);
        check({tag, " ibeat"},   32'(ibeat),   32'(eb));
        check({tag, " state"},   32'(state),   32'(es));
        check({tag, " looping"}, 32'(looping), 32'(es == LP));
        check({tag, " wrap"},    32'(wrap),    32'(ew));
    endtask

    int wraps;
    int held;
    int after_resume;

    initial begin
        rst = 1'b0; beat_tick = 1'b0; play = 1'b0; reverse = 1'b0; loop_en = 1'b0;
        loop_notes = '0; seek_valid = 1'b0; seek_ibeat = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 0, PA, 1'b0);
        rst = 1'b1;

        // Forward play through the whole song: 1..63 then 0 with a single wrap.
        play = 1'b1;
        @(posedge clk); #1;
        check_outputs("play_start", 0, PL, 1'b0);
        beat_tick = 1'b1;
        wraps = 0;
        for (int i = 1; i <= LEN; i++) begin
            @(posedge clk); #1;
            check($sformatf("fwd%0d ibeat", i), 32'(ibeat), 32'(i % LEN));
            check($sformatf("fwd%0d wrap", i), 32'(wrap), 32'(i == LEN));
            wraps += int'(wrap);
        end
        beat_tick = 1'b0;
        check("fwd wrap_count", 32'(wraps), 32'd1);

        // Reverse through 0 into LEN-1.
        add(1, 1,  1, 0, 0, 0, 0,  1, PL, 0);
        add(0, 0,  1, 1, 0, 0, 1,  0, PL, 0);
        add(0, 0,  1, 1, 0, 0, 1, 63, PL, 1);
        add(0, 0,  1, 1, 0, 0, 0, 63, PL, 0);
        // Forward loop capture at 10, two notes: window 4..11.
        add(1, 10, 1, 0, 0, 2, 0, 10, PL, 0);
        add(0, 0,  1, 0, 1, 2, 0, 10, LP, 0);
        add(0, 0,  1, 0, 1, 2, 1, 11, LP, 0);
        add(0, 0,  1, 0, 1, 2, 1,  4, LP, 1);
        for (int b = 5; b <= 11; b++) add(0, 0, 1, 0, 1, 2, 1, b, LP, 0);
        add(0, 0,  1, 0, 1, 2, 1,  4, LP, 1);
        add(0, 0,  1, 0, 0, 2, 0,  4, PL, 0);
        // Reverse loop capture at 2, three notes: window 0..11; later loop_notes ignored.
        add(1, 2,  1, 0, 0, 3, 0,  2, PL, 0);
        add(0, 0,  1, 1, 1, 3, 0,  2, LP, 0);
        add(0, 0,  1, 1, 1, 3, 1,  1, LP, 0);
        add(0, 0,  1, 1, 1, 3, 1,  0, LP, 0);
        add(0, 0,  1, 1, 1, 3, 1, 11, LP, 1);
        for (int b = 10; b >= 6; b--) add(0, 0, 1, 1, 1, 1, 1, b, LP, 0);
        // Seek out of LOOP clips to LEN-1; held loop_en does not re-enter.
        add(1, 100, 1, 1, 1, 1, 0, 63, PL, 0);
        add(0, 0,  1, 1, 1, 1, 1, 62, PL, 0);
        add(0, 0,  1, 0, 1, 1, 1, 63, PL, 0);
        add(0, 0,  1, 0, 1, 1, 1,  0, PL, 1);
        // Pause mid-loop holds ibeat and keeps the window for resume.
        add(0, 0,  1, 0, 0, 2, 0,  0, PL, 0);
        add(1, 10, 1, 0, 0, 2, 0, 10, PL, 0);
        add(0, 0,  1, 0, 1, 2, 0, 10, LP, 0);
`ifdef BEAT_SEQ_PINGPONG_EN
        add(0, 0,  1, 0, 1, 2, 1, 11, LP, 1);
        add(0, 0,  1, 0, 1, 2, 1, 10, LP, 0);
        add(0, 0,  1, 0, 1, 2, 1,  9, LP, 0);
        held = 9;  after_resume = 10;
`else
        add(0, 0,  1, 0, 1, 2, 1, 11, LP, 0);
        add(0, 0,  1, 0, 1, 2, 1,  4, LP, 1);
        add(0, 0,  1, 0, 1, 2, 1,  5, LP, 0);
        held = 5;  after_resume = 6;
`endif
        for (int k = 0; k < 5; k++) add(0, 0, 0, 0, 1, 2, 1, held, PA, 0);
        add(0, 0,  1, 0, 1, 2, 0, held, LP, 0);
        add(0, 0,  1, 0, 1, 2, 1, after_resume, LP, 0);

        foreach (vq[i]) begin
            seek_valid = vq[i].sv;
            seek_ibeat = IBEAT_W'(vq[i].sk);
            play       = vq[i].pl;
            reverse    = vq[i].rv;
            loop_en    = vq[i].le;
            loop_notes = LOOP_W'(vq[i].ln);
            beat_tick  = vq[i].tk;
            @(posedge clk); #1;
            check_outputs($sformatf("vec%0d", i), vq[i].e_ibeat, vq[i].e_state, vq[i].e_wrap);
        end
        seek_valid = 1'b0;
        beat_tick  = 1'b0;

        // Mid-loop reset discards the window; held loop_en alone cannot re-enter LOOP.
        rst = 1'b0;
        @(posedge clk); #1;
        check_outputs("midrst", 0, PA, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_outputs("midrst_resume", 0, PL, 1'b0);
        @(posedge clk); #1;
        check_outputs("midrst_noloop", 0, PL, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/beat_sequencer.md
Name: beat_sequencer

Overview:
Parametrised successor to the beat-index player controller. Generates the playback beat index (ibeat) for the song ROM and LED display. Supports play/pause, forward/reverse, a loop window captured in whole notes, seek, and a wrap strobe. Advances only on an external beat tick, not every clock, so one instance serves any tempo divider.

Parameters:
IBEAT_W, 12, width of ibeat and seek_ibeat.
LEN, 4095, number of beats in the song; valid ibeat range is 0..LEN-1. Must satisfy LEN <= 2**IBEAT_W.
NOTE_BEATS, 4, beats per note; power of two, at least 2.
LOOP_W, 3, width of loop_notes; the loop window is at most 2**LOOP_W-1 notes.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-low (rst=0 resets on the rising edge of clk).
beat_tick  in  1  one-cycle advance strobe from the tempo divider.
play  in  1  level: 1=play, 0=pause.
reverse  in  1  level: 1=count down.
loop_en  in  1  level; a rising edge arms the loop.
loop_notes  in  LOOP_W  loop window length in notes; 0 is treated as 1.
seek_valid  in  1  one-cycle load request.
seek_ibeat  in  IBEAT_W  load target.
ibeat  out  IBEAT_W  current beat index.
state  out  2  current state: 0=PAUSE, 1=PLAY, 2=LOOP.
looping  out  1  1 while in LOOP.
wrap  out  1  one-cycle pulse on a song wrap or loop jump.

Behaviour:
- Reset (rst=0 at a clk edge):
  - ibeat=0, state=PAUSE, looping=0, wrap=0.
  - loop_start=0, loop_end=0; the loop_en edge register is cleared.
  - A mid-operation reset discards the captured window.
- State machine, with priority in this order:
  - seek_valid=1 (any state): ibeat <= min(seek_ibeat, LEN-1). LOOP exits to PLAY if play=1, otherwise PAUSE. No step occurs that cycle. Re-entering LOOP needs a fresh loop_en rising edge.
  - play=0: go to PAUSE, hold ibeat, keep the window.
  - PAUSE with play=1: go to PLAY, or to LOOP if loop_en=1 and a window was captured and not cancelled.
  - PLAY, loop_en rising edge: capture the window and go to LOOP the same cycle. ibeat is not changed by the capture.
  - LOOP with loop_en=0: go to PLAY; ibeat continues linearly from its current value.
- Window capture (n = max(loop_notes,1), S = n*NOTE_BEATS):
  - forward: loop_end = ibeat | (NOTE_BEATS-1), clipped to LEN-1; loop_start = max(loop_end+1-S, 0).
  - reverse: loop_start = ibeat & ~(NOTE_BEATS-1); loop_end = min(loop_start+S-1, LEN-1).
  - The window is frozen until the next capture. Later loop_notes changes are ignored.
- Step. A step happens only in PLAY or LOOP, only when beat_tick=1, and only when seek_valid=0. Registered; ibeat updates the cycle after the tick.
  - PLAY forward: LEN-1 -> 0 with wrap=1; otherwise +1.
  - PLAY reverse: 0 -> LEN-1 with wrap=1; otherwise -1. Beat 0 is visited.
  - LOOP forward: at ibeat==loop_end jump to loop_start with wrap=1; otherwise +1.
  - LOOP reverse: at ibeat==loop_start jump to loop_end with wrap=1; otherwise -1.
  - If ibeat is outside the window in LOOP (possible after a reverse toggle), step normally until it reaches the window's far edge.
- reverse may toggle at any cycle. It takes effect on the next tick and does not recapture the window.
- wrap is registered, high for exactly the cycle in which the new ibeat is presented.
- All arithmetic uses IBEAT_W+1 bits internally; there is no unsigned underflow at 0.

Optional Feature:
Macro BEAT_SEQ_PINGPONG_EN.
- Defined: in LOOP, reaching loop_end (forward) or loop_start (reverse) flips an internal direction bit instead of jumping, and wrap still pulses.
  - The effective direction is reverse XOR the internal bit.
  - The internal bit clears on leaving LOOP.
- Undefined: jump behaviour as above; no extra flop.

Decomposition:
- Package beat_seq_pkg:
  - state encoding constants ST_PAUSE=0, ST_PLAY=1, ST_LOOP=2;
  - the default NOTE_BEATS.
- One combinational sub-module, loop_window_calc: inputs ibeat, reverse, loop_notes; outputs loop_start, loop_end. Instantiated once.
- The FSM and step logic stay in beat_sequencer.

Test Plan:
1. LEN=64, play=1, reverse=0, 64 ticks from reset -> ibeat 1..63 then 0; wrap pulses once, on the 0.
2. reverse=1 from ibeat=1, two ticks -> 0, then 63 with wrap=1.
3. ibeat=10, loop_notes=2, loop_en rising, forward -> window 4..11; ticks give 11, 4, 5, ..., 11, 4, with wrap on each 4.
4. ibeat=2, loop_notes=3, reverse=1, loop_en rising -> window 0..11; ticks give 1, 0, 11 with wrap; a loop_notes change to 1 afterwards has no effect.
5. In LOOP at ibeat=6, seek_valid with seek_ibeat=100 (LEN=64) -> ibeat=63, state=PLAY, looping=0; loop_en still high does not re-enter LOOP.
6. play=0 mid-loop for 5 ticks -> ibeat held, state=PAUSE. With BEAT_SEQ_PINGPONG_EN, window 4..11 -> ibeat 10, 11, 10, 9, ... with wrap at 11.
